// File: rtl/fp32_pkg.sv
// Shared types and constants for the single-precision multiplier.
package fp32_pkg;

  localparam int BIAS    = 127;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int MANT_W  = 24;
  localparam int PROD_W  = 2 * MANT_W;
  localparam int N_ITERS = 24;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_MUL,
    ST_ROUND,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
  } fp_class_t;

  // Denormals land in the zero class: they are flushed on input.
  function automatic fp_class_t classify(input logic [31:0] x);
    fp_class_t c;
    c.zero = (x[30:23] == '0);
    c.inf  = (x[30:23] == '1) && (x[22:0] == '0);
    c.nan  = (x[30:23] == '1) && (x[22:0] != '0);
    return c;
  endfunction

endpackage

// File: rtl/fp32_round_pack.sv
// Normalize, round-to-nearest-even and pack the raw 48-bit mantissa product,
// with special-operand and exponent-range overrides. Purely combinational.
module fp32_round_pack
  import fp32_pkg::*;
(
  input  logic               sign,
  input  logic [EXP_W-1:0]   exp_a,
  input  logic [EXP_W-1:0]   exp_b,
  input  fp_class_t          cls_a,
  input  fp_class_t          cls_b,
  input  logic [PROD_W-1:0]  prod,
  output logic [31:0]        result
);

  logic signed [9:0]  e_raw;
  logic signed [9:0]  e_norm;
  logic signed [9:0]  e_fin;
  logic [MANT_W-1:0]  mant;
  logic               guard;
  logic               rnd;
  logic               sticky;
  logic               inc;
  logic [MANT_W:0]    mant_r;
  logic [FRAC_W-1:0]  frac;

  // Exponent sum, one-bit normalization, then RNE with carry into the exponent.
  always_comb begin
    e_raw = 10'(exp_a) + 10'(exp_b) - 10'(BIAS);
    if (prod[PROD_W-1]) begin
      mant   = prod[PROD_W-1:PROD_W-MANT_W];
      guard  = prod[PROD_W-MANT_W-1];
      rnd    = prod[PROD_W-MANT_W-2];
      sticky = |prod[PROD_W-MANT_W-3:0];
      e_norm = e_raw + 10'sd1;
    end else begin
      mant   = prod[PROD_W-2:PROD_W-MANT_W-1];
      guard  = prod[PROD_W-MANT_W-2];
      rnd    = prod[PROD_W-MANT_W-3];
      sticky = |prod[PROD_W-MANT_W-4:0];
      e_norm = e_raw;
    end
    inc    = guard & (rnd | sticky | mant[0]);
    mant_r = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
    if (mant_r[MANT_W]) begin
      e_fin = e_norm + 10'sd1;
      frac  = mant_r[MANT_W-1:1];
    end else begin
      e_fin = e_norm;
      frac  = mant_r[FRAC_W-1:0];
    end
  end

  // NaN beats infinity beats zero; finite results are then range-checked.
  always_comb begin
    result = '0;
    if (cls_a.nan || cls_b.nan || (cls_a.inf && cls_b.zero) || (cls_a.zero && cls_b.inf))
      result = QNAN;
    else if (cls_a.inf || cls_b.inf)
      result = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    else if (cls_a.zero || cls_b.zero)
      result = {sign, 31'd0};
    else if (e_fin >= 10'sd255)
      result = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    else if (e_fin <= 10'sd0)
      result = {sign, 31'd0};
    else
      result = {sign, e_fin[EXP_W-1:0], frac};
  end

endmodule

// File: rtl/fp32_mul_core.sv
// Sequential IEEE-754 single-precision multiplier: one shift-add step per
// clock, fixed 26-edge latency from accept to the ready pulse.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for clken; operands latched on accept
//   ST_UNPACK | split fields, insert hidden bits, classify, clear counter
//   ST_MUL    | MUL_ITERS radix-2 shift-add steps into the 48-bit product
//   ST_ROUND  | d_out loaded from the round/pack logic on leaving
//   ST_DONE   | ready high; a held clken restarts here (27-edge cadence)
module fp32_mul_core
  import fp32_pkg::*;
#(
  parameter int MUL_ITERS = N_ITERS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clken,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  output logic [31:0] d_out,
  output logic        ready,
  output logic        busy
);

  localparam int CNT_W = $clog2(MUL_ITERS);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_ITERS - 1);

  state_t             state;
  state_t             state_next;
  logic               accept;
  logic [31:0]        op_a;
  logic [31:0]        op_b;
  logic               sign_r;
  logic [EXP_W-1:0]   exp_a;
  logic [EXP_W-1:0]   exp_b;
  fp_class_t          cls_a;
  fp_class_t          cls_b;
  logic [PROD_W-1:0]  mcand;
  logic [MANT_W-1:0]  mplier;
  logic [PROD_W-1:0]  prod;
  logic [CNT_W-1:0]   iter;
  logic [31:0]        result;

  assign accept = clken && ((state == ST_IDLE) || (state == ST_DONE));
  assign ready  = (state == ST_DONE);
  assign busy   = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (clken) state_next = ST_UNPACK;
      ST_UNPACK: state_next = ST_MUL;
      ST_MUL:    if (iter == LAST_ITER) state_next = ST_ROUND;
      ST_ROUND:  state_next = ST_DONE;
      ST_DONE:   state_next = clken ? ST_UNPACK : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Operand latches: captured only on the accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a <= '0;
      op_b <= '0;
    end else if (accept) begin
      op_a <= data1;
      op_b <= data2;
    end
  end

  // Field split and operand classification.
  always_ff @(posedge clk) begin
    if (reset) begin
      sign_r <= 1'b0;
      exp_a  <= '0;
      exp_b  <= '0;
      cls_a  <= '0;
      cls_b  <= '0;
    end else if (state == ST_UNPACK) begin
      sign_r <= op_a[31] ^ op_b[31];
      exp_a  <= op_a[FRAC_W +: EXP_W];
      exp_b  <= op_b[FRAC_W +: EXP_W];
      cls_a  <= classify(op_a);
      cls_b  <= classify(op_b);
    end
  end

  // Shift-add multiplier: multiplicand walks left, multiplier walks right.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      iter   <= '0;
    end else if (state == ST_UNPACK) begin
      mcand  <= {{(PROD_W-MANT_W){1'b0}}, 1'b1, op_a[FRAC_W-1:0]};
      mplier <= {1'b1, op_b[FRAC_W-1:0]};
      prod   <= '0;
      iter   <= '0;
    end else if (state == ST_MUL) begin
      if (mplier[0]) prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      iter   <= iter + 1'b1;
    end
  end

  fp32_round_pack u_round_pack (
    .sign   (sign_r),
    .exp_a  (exp_a),
    .exp_b  (exp_b),
    .cls_a  (cls_a),
    .cls_b  (cls_b),
    .prod   (prod),
    .result (result)
  );

  // Output register: updated only when leaving ROUND.
  always_ff @(posedge clk) begin
    if (reset)                  d_out <= '0;
    else if (state == ST_ROUND) d_out <= result;
  end

endmodule
